// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - packs decoded RV32I fields into instruction words with PC tagging and immediate checks
module instr_encoder #(
    parameter logic [31:0] BASE_PC = 32'h0000_0000,
    parameter int          CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       opcode,
    input  logic [4:0]       rd,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic [31:0]      imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      instr,
    output logic [31:0]      pc,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [31:0]      err_pc,
    output logic [CNT_W-1:0] count
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] E_NONE  = 2'b00;
    localparam logic [1:0] E_OPC   = 2'b01;
    localparam logic [1:0] E_RANGE = 2'b10;
    localparam logic [1:0] E_ALIGN = 2'b11;

    logic        accept;
    logic [31:0] next_pc;
    logic [31:0] enc_word;
    logic [1:0]  enc_err;
    logic        fits12;
    logic        fits13;
    logic        fits21;
    logic        is_shift;

    assign in_ready = !clear && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // Each fitsN means imm is exactly the sign-extension of its low N bits.
    assign fits12   = (imm[31:11] == {21{imm[11]}});
    assign fits13   = (imm[31:12] == {20{imm[12]}});
    assign fits21   = (imm[31:20] == {12{imm[20]}});
    assign is_shift = (opcode == OP_IMM) && ((funct3 == 3'b001) || (funct3 == 3'b101));

    always_comb begin
        enc_word = 32'h0000_0013;
        enc_err  = E_NONE;
        case (opcode)
            OP_R: begin
                enc_word = {funct7, rs2, rs1, funct3, rd, opcode};
            end
            OP_IMM, OP_LOAD, OP_JALR: begin
                if (is_shift) begin
                    enc_word = {funct7, imm[4:0], rs1, funct3, rd, opcode};
                    if (imm[31:5] != 27'd0) enc_err = E_RANGE;
                end else begin
                    enc_word = {imm[11:0], rs1, funct3, rd, opcode};
                    if (!fits12) enc_err = E_RANGE;
                end
            end
            OP_STORE: begin
                enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                if (!fits12) enc_err = E_RANGE;
            end
            OP_BRANCH: begin
                enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                if (!fits13)     enc_err = E_RANGE;
                else if (imm[0]) enc_err = E_ALIGN;
            end
            OP_LUI, OP_AUIPC: begin
                enc_word = {imm[31:12], rd, opcode};
                if (imm[11:0] != 12'd0) enc_err = E_ALIGN;
            end
            OP_JAL: begin
                enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                if (!fits21)     enc_err = E_RANGE;
                else if (imm[0]) enc_err = E_ALIGN;
            end
            default: begin
                enc_err = E_OPC;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            instr     <= 32'd0;
            pc        <= 32'd0;
            err       <= 1'b0;
            err_code  <= 2'b00;
            err_pc    <= 32'd0;
            count     <= '0;
            next_pc   <= BASE_PC;
        end else if (clear) begin
            out_valid <= 1'b0;
            err       <= 1'b0;
            err_code  <= 2'b00;
            err_pc    <= 32'd0;
            count     <= '0;
            next_pc   <= BASE_PC;
        end else if (accept) begin
            out_valid <= 1'b1;
            instr     <= enc_word;
            pc        <= next_pc;
            next_pc   <= next_pc + 32'd4;
            count     <= count + CNT_W'(1);
            // Only the first failing bundle is recorded until clear/reset.
            if ((enc_err != E_NONE) && !err) begin
                err      <= 1'b1;
                err_code <= enc_err;
                err_pc   <= next_pc;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
